// File: rtl/switch_press_classifier.sv
// rtl/switch_press_classifier.sv - classifies a debounced switch level into press/release/short/double/long pulses
module switch_press_classifier #(
    parameter int c_LONG_PRESS  = 12500000,
    parameter int c_DOUBLE_GAP  = 6250000,
    parameter int c_COUNT_WIDTH = 24
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Short,
    output logic o_Double,
    output logic o_Long,
    output logic o_Busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS1,
        ST_LONG,
        ST_WAIT_GAP,
        ST_PRESS2
    } state_t;

    localparam logic [c_COUNT_WIDTH-1:0] LONG_LAST = c_COUNT_WIDTH'(c_LONG_PRESS - 1);
    localparam logic [c_COUNT_WIDTH-1:0] GAP_LAST  = c_COUNT_WIDTH'(c_DOUBLE_GAP - 1);

    state_t                   state_q, state_d;
    logic [c_COUNT_WIDTH-1:0] count_q, count_d;
    logic                     sw_q;
    logic                     press_q, release_q, short_q, double_q, long_q;
    logic                     short_d, double_d, long_d;
    logic                     rise, fall;

    assign rise = i_Switch & ~sw_q;
    assign fall = ~i_Switch & sw_q;

    // Counter restarts on every state change, so it never runs past a threshold
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS1;
                    count_d = '0;
                end
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_WAIT_GAP;
                    count_d = '0;
                end else if (count_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            end
            ST_WAIT_GAP: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                    count_d = '0;
                end else if (count_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = ST_IDLE;
                    count_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            sw_q      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sw_q      <= i_Switch;
            press_q   <= rise;
            release_q <= fall;
            short_q   <= short_d;
            double_q  <= double_d;
            long_q    <= long_d;
        end
    end

    assign o_Press   = press_q;
    assign o_Release = release_q;
    assign o_Short   = short_q;
    assign o_Double  = double_q;
    assign o_Long    = long_q;
    assign o_Busy    = (state_q != ST_IDLE);

    a_params_ok: assert property (@(posedge i_Clk)
        (c_LONG_PRESS >= 2) && (longint'(c_LONG_PRESS) < (longint'(1) << c_COUNT_WIDTH)) &&
        (c_DOUBLE_GAP >= 2) && (longint'(c_DOUBLE_GAP) < (longint'(1) << c_COUNT_WIDTH)));

    a_one_event: assert property (@(posedge i_Clk) disable iff (!i_Rst_L)
        $onehot0({short_q, double_q, long_q}));

endmodule

// File: tb/tb_switch_press_classifier.sv
// tb/tb_switch_press_classifier.sv - vector table, async reset sequences and random run against a timestamp model
module tb_switch_press_classifier;

    localparam int LONG = 8;
    localparam int GAP  = 5;

    logic i_Clk, i_Rst_L, i_Switch;
    logic o_Press, o_Release, o_Short, o_Double, o_Long, o_Busy;

    switch_press_classifier #(
        .c_LONG_PRESS (LONG),
        .c_DOUBLE_GAP (GAP),
        .c_COUNT_WIDTH(4)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Switch (i_Switch),
        .o_Press  (o_Press),
        .o_Release(o_Release),
        .o_Short  (o_Short),
        .o_Double (o_Double),
        .o_Long   (o_Long),
        .o_Busy   (o_Busy)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Expected word layout: {press, release, short, double, long, busy}
    typedef struct {
        logic       rst_n;
        logic       sw;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [5:0] outs();
        return {o_Press, o_Release, o_Short, o_Double, o_Long, o_Busy};
    endfunction

    function automatic void push(input logic r, input logic s, input logic [5:0] e);
        vec_t v;
        v.rst_n = r;
        v.sw    = s;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b (press,release,short,double,long,busy)",
                     name, $time, act, exp);
        end
    endtask

    // Reference model in terms of edge timestamps rather than a cycle counter
    bit m_prev, m_first, m_long, m_gap, m_second;
    int m_t, m_trise, m_tfall;

    task automatic model_reset();
        m_prev = 0; m_first = 0; m_long = 0; m_gap = 0; m_second = 0;
        m_t = 0; m_trise = 0; m_tfall = 0;
    endtask

    task automatic model_edge(input logic sw, output logic [5:0] e);
        logic rise, fall, s, d, l, busy;
        rise = sw & ~m_prev;
        fall = ~sw & m_prev;
        m_prev = sw;
        m_t++;
        s = 0; d = 0; l = 0;
        if (m_first) begin
            if (fall) begin
                m_first = 0; m_gap = 1; m_tfall = m_t;
            end else if (m_t - m_trise == LONG) begin
                l = 1; m_first = 0; m_long = 1;
            end
        end else if (m_long) begin
            if (fall) m_long = 0;
        end else if (m_gap) begin
            if (rise) begin
                m_gap = 0; m_second = 1;
            end else if (m_t - m_tfall == GAP) begin
                s = 1; m_gap = 0;
            end
        end else if (m_second) begin
            if (fall) begin
                d = 1; m_second = 0;
            end
        end else if (rise) begin
            m_first = 1; m_trise = m_t;
        end
        busy = m_first | m_long | m_gap | m_second;
        e = {rise, fall, s, d, l, busy};
    endtask

    initial begin
        logic [5:0] e;
        logic       sw;
        int         run;

        i_Rst_L  = 1'b0;
        i_Switch = 1'b0;

        // Reset held while toggling, then released with the switch high
        push(0, 0, 6'b000000); push(0, 1, 6'b000000);
        push(0, 0, 6'b000000); push(0, 1, 6'b000000);
        push(1, 1, 6'b100001);
        push(1, 0, 6'b010001);
        for (int k = 1; k < GAP; k++) push(1, 0, 6'b000001);
        push(1, 0, 6'b001000);
        push(1, 0, 6'b000000);
        // Short click: fall three edges after the rise
        push(1, 1, 6'b100001);
        push(1, 1, 6'b000001); push(1, 1, 6'b000001);
        push(1, 0, 6'b010001);
        for (int k = 1; k < GAP; k++) push(1, 0, 6'b000001);
        push(1, 0, 6'b001000);
        push(1, 0, 6'b000000);
        // Double click
        push(1, 1, 6'b100001);
        push(1, 1, 6'b000001); push(1, 1, 6'b000001);
        push(1, 0, 6'b010001);
        push(1, 0, 6'b000001);
        push(1, 1, 6'b100001);
        push(1, 1, 6'b000001); push(1, 1, 6'b000001);
        push(1, 0, 6'b010100);
        push(1, 0, 6'b000000);
        // Second rise exactly at the gap limit
        push(1, 1, 6'b100001);
        push(1, 0, 6'b010001);
        for (int k = 1; k < GAP; k++) push(1, 0, 6'b000001);
        push(1, 1, 6'b100001);
        push(1, 0, 6'b010100);
        push(1, 0, 6'b000000);
        // Second rise one edge too late: short, then a fresh first press
        push(1, 1, 6'b100001);
        push(1, 0, 6'b010001);
        for (int k = 1; k < GAP; k++) push(1, 0, 6'b000001);
        push(1, 0, 6'b001000);
        push(1, 1, 6'b100001);
        push(1, 0, 6'b010001);
        for (int k = 1; k < GAP; k++) push(1, 0, 6'b000001);
        push(1, 0, 6'b001000);
        push(1, 0, 6'b000000);
        // Long hold for 20 edges, then release without a short
        push(1, 1, 6'b100001);
        for (int k = 1; k <= 20; k++) push(1, 1, (k == LONG) ? 6'b000011 : 6'b000001);
        push(1, 0, 6'b010000);
        for (int k = 0; k < 6; k++) push(1, 0, 6'b000000);

        foreach (vecs[i]) begin
            i_Rst_L  = vecs[i].rst_n;
            i_Switch = vecs[i].sw;
            @(posedge i_Clk);
            @(negedge i_Clk);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Async reset in the middle of a first press, with count at 4
        i_Switch = 1'b1;
        @(posedge i_Clk); @(negedge i_Clk);
        check("mid_rise", outs(), 6'b100001);
        for (int k = 1; k <= 4; k++) begin
            @(posedge i_Clk); @(negedge i_Clk);
        end
        check("mid_busy", outs(), 6'b000001);
        #1 i_Rst_L = 1'b0;
        #1 check("async_rst_now", outs(), 6'b000000);
        @(posedge i_Clk); @(negedge i_Clk);
        check("async_rst_held", outs(), 6'b000000);
        i_Rst_L = 1'b1;
        @(posedge i_Clk); @(negedge i_Clk);
        check("post_rst_press", outs(), 6'b100001);
        for (int k = 1; k <= 10; k++) begin
            @(posedge i_Clk); @(negedge i_Clk);
            check($sformatf("post_rst_hold%0d", k), outs(), (k == LONG) ? 6'b000011 : 6'b000001);
        end
        i_Switch = 1'b0;
        @(posedge i_Clk); @(negedge i_Clk);
        check("post_rst_release", outs(), 6'b010000);

        // Random run against the model, with occasional async resets
        i_Rst_L = 1'b0;
        @(posedge i_Clk); @(negedge i_Clk);
        i_Rst_L = 1'b1;
        model_reset();
        sw  = 1'b0;
        run = 1;
        for (int c = 0; c < 3000; c++) begin
            run--;
            if (run == 0) begin
                sw  = ~sw;
                run = $urandom_range(1, 12);
            end
            i_Switch = sw;
            @(posedge i_Clk);
            model_edge(sw, e);
            @(negedge i_Clk);
            check($sformatf("rand%0d", c), outs(), e);
            if ($urandom_range(0, 249) == 0) begin
                i_Rst_L = 1'b0;
                #2 check($sformatf("rand_rst%0d", c), outs(), 6'b000000);
                model_reset();
                i_Rst_L = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
